// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: FSM states, line-code enums,
// the latched per-frame configuration and the data-width decode.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  typedef enum logic [1:0] {
    STOP_ONE      = 2'd0,
    STOP_ONE_HALF = 2'd1,
    STOP_TWO      = 2'd2
  } stop_e;

  // Raw 2-bit fields are kept because code 3 is legal on both inputs.
  typedef struct packed {
    logic [3:0]  width;
    logic [15:0] baud_max;
    logic [1:0]  parity;
    logic [1:0]  stop;
  } rx_cfg_t;

  function automatic logic [3:0] data_width(input logic [3:0] code);
    case (code)
      4'd5, 4'd6, 4'd7, 4'd8: return code;
      default:                return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx pin plus a
// falling-edge detector; both flop chains reset to the idle-high level.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx_i};
    rx_prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign fall_pulse = rx_prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx_logic.sv
// UART receive engine: start-edge detection, mid-bit sampling, parity and
// stop checking, and a one-cycle strobe carrying the byte and error flags.
module uart_rx_logic
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  uart_data_bit,
  input  logic [15:0] uart_bps_baud_cnt_max,
  input  logic [1:0]  uart_parity_bit,
  input  logic [1:0]  uart_stop_bit,
  input  logic        rx_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_data_flag_o,
  output logic        rx_parity_err_o,
  output logic        rx_frame_err_o,
  output logic        rx_busy_o
);

  rx_state_e   state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  rx_cfg_t     cfg_q, cfg_d;
  logic        par_err_q, par_err_d;
  logic        frm_err_q, frm_err_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        flag_q, flag_d;
  logic        perr_out_q, perr_out_d;
  logic        ferr_out_q, ferr_out_d;

  logic rx_s, fall_pulse;
  logic sample_pt, baud_wrap, parity_en, parity_exp, last_stop;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (sys_clk_i),
    .rst_n      (rst_n_i),
    .rx_i       (rx_i),
    .rx_s       (rx_s),
    .fall_pulse (fall_pulse)
  );

  assign sample_pt  = (baud_cnt_q == (cfg_q.baud_max >> 1));
  assign baud_wrap  = (baud_cnt_q == cfg_q.baud_max);
  assign parity_en  = (cfg_q.parity == PARITY_ODD) || (cfg_q.parity == PARITY_EVEN);
  // Bits above the configured width stay 0, so a full-byte reduction is exact.
  assign parity_exp = (cfg_q.parity == PARITY_ODD) ? ~^shift_q : ^shift_q;
  assign last_stop  = (cfg_q.stop != STOP_TWO) || (bit_cnt_q == 4'd1);

  // NOTE: every _d gets its default first, so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    cfg_d      = cfg_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    rx_data_d  = rx_data_q;
    flag_d     = 1'b0;
    perr_out_d = 1'b0;
    ferr_out_d = 1'b0;
    baud_cnt_d = (state_q == ST_IDLE || baud_wrap) ? 16'd0 : baud_cnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (fall_pulse) begin
          state_d   = ST_START;
          bit_cnt_d = 4'd0;
          shift_d   = 8'd0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
          cfg_d     = '{width:    data_width(uart_data_bit),
                        baud_max: uart_bps_baud_cnt_max,
                        parity:   uart_parity_bit,
                        stop:     uart_stop_bit};
        end
      end
      ST_START: begin
        if (sample_pt) begin
          state_d   = rx_s ? ST_IDLE : ST_DATA;
          bit_cnt_d = 4'd0;
        end
      end
      ST_DATA: begin
        if (sample_pt) begin
          shift_d[bit_cnt_q[2:0]] = rx_s;
          if (bit_cnt_q == cfg_q.width - 4'd1) begin
            bit_cnt_d = 4'd0;
            state_d   = parity_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (sample_pt) begin
          par_err_d = (rx_s != parity_exp);
          bit_cnt_d = 4'd0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_pt) begin
          frm_err_d = frm_err_q | ~rx_s;
          if (last_stop) begin
            state_d    = ST_IDLE;
            flag_d     = 1'b1;
            rx_data_d  = shift_q;
            perr_out_d = par_err_q;
            ferr_out_d = frm_err_q | ~rx_s;
          end else begin
            bit_cnt_d = 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      cfg_q      <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      rx_data_q  <= 8'd0;
      flag_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      cfg_q      <= cfg_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      rx_data_q  <= rx_data_d;
      flag_q     <= flag_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  assign rx_data_o       = rx_data_q;
  assign rx_data_flag_o  = flag_q;
  assign rx_parity_err_o = perr_out_q;
  assign rx_frame_err_o  = ferr_out_q;
  assign rx_busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_logic.sv
// Self-checking bench for uart_rx_logic: a table of directed frames, hand
// sequences for glitch/back-to-back/reset, then randomized frames vs a model.
module tb_uart_rx_logic;

  logic        sys_clk_i = 1'b0;
  logic        rst_n_i   = 1'b0;
  logic [3:0]  uart_data_bit = 4'd8;
  logic [15:0] uart_bps_baud_cnt_max = 16'd40;
  logic [1:0]  uart_parity_bit = 2'd0;
  logic [1:0]  uart_stop_bit = 2'd0;
  logic        rx_i = 1'b1;
  logic [7:0]  rx_data_o;
  logic        rx_data_flag_o, rx_parity_err_o, rx_frame_err_o, rx_busy_o;

  uart_rx_logic #(.SYNC_STAGES(2)) dut (
    .sys_clk_i             (sys_clk_i),
    .rst_n_i               (rst_n_i),
    .uart_data_bit         (uart_data_bit),
    .uart_bps_baud_cnt_max (uart_bps_baud_cnt_max),
    .uart_parity_bit       (uart_parity_bit),
    .uart_stop_bit         (uart_stop_bit),
    .rx_i                  (rx_i),
    .rx_data_o             (rx_data_o),
    .rx_data_flag_o        (rx_data_flag_o),
    .rx_parity_err_o       (rx_parity_err_o),
    .rx_frame_err_o        (rx_frame_err_o),
    .rx_busy_o             (rx_busy_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int unsigned cyc = 0;
  always @(posedge sys_clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    int unsigned cyc;
  } rec_t;

  typedef struct {
    logic [3:0]  db;
    logic [15:0] mx;
    logic [1:0]  par;
    logic [1:0]  stp;
    logic [7:0]  data;
    logic        pflip;
    logic        s1;
    logic        s2;
    logic [7:0]  e_data;
    logic        e_perr;
    logic        e_ferr;
  } vec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  int   stray  = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Strobe monitor; error flags outside a strobe are counted as strays.
  always @(negedge sys_clk_i) begin
    if (rx_data_flag_o)
      got_q.push_back('{rx_data_o, rx_parity_err_o, rx_frame_err_o, cyc});
    else if (rx_parity_err_o || rx_frame_err_o)
      stray++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_level(input logic v, input int cycles);
    rx_i = v;
    repeat (cycles) @(posedge sys_clk_i);
    #1;
  endtask

  // Drives one frame bit by bit and returns the expected result computed
  // from the frame rules (masking, parity count, stop levels).
  task automatic send_frame(input logic [3:0] db, input logic [15:0] mx,
                            input logic [1:0] par, input logic [1:0] stp,
                            input logic [7:0] data, input logic pflip,
                            input logic s1, input logic s2, input bit scramble,
                            output rec_t mexp, output int unsigned start_cyc);
    int         p, w, ones;
    logic [7:0] d;
    logic       pbit, par_en, last;
    p      = int'(mx) + 1;
    w      = (db >= 4'd5 && db <= 4'd8) ? int'(db) : 8;
    d      = data & 8'((1 << w) - 1);
    ones   = $countones(d);
    par_en = (par == 2'd1) || (par == 2'd2);
    pbit   = ((par == 2'd1) ? ~ones[0] : ones[0]) ^ pflip;
    mexp.data = d;
    mexp.perr = par_en && (((ones + int'(pbit)) % 2) != ((par == 2'd1) ? 1 : 0));
    mexp.ferr = !s1 || (stp == 2'd2 && !s2);
    mexp.cyc  = 0;

    uart_data_bit         = db;
    uart_bps_baud_cnt_max = mx;
    uart_parity_bit       = par;
    uart_stop_bit         = stp;
    start_cyc = cyc;
    drive_level(1'b0, p);
    if (scramble) begin
      uart_data_bit         = 4'($urandom_range(0, 15));
      uart_bps_baud_cnt_max = 16'($urandom_range(3, 200));
      uart_parity_bit       = 2'($urandom_range(0, 3));
      uart_stop_bit         = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < w; i++) drive_level(d[i], p);
    if (par_en) drive_level(pbit, p);
    drive_level(s1, p);
    last = s1;
    if (stp == 2'd2) begin
      drive_level(s2, p);
      last = s2;
    end else if (stp == 2'd1) begin
      drive_level(1'b1, p / 2);
      last = 1'b1;
    end
    if (!last) drive_level(1'b1, p);
    rx_i = 1'b1;
  endtask

  task automatic drain(input string tag, input int mx, output int unsigned first_cyc);
    int   budget, n;
    rec_t e, g;
    budget = 4 * (mx + 1) + 40;
    n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      @(posedge sys_clk_i);
      n++;
    end
    repeat (2 * (mx + 1) + 8) @(posedge sys_clk_i);
    #1;
    check({tag, "_strobes"}, 32'(got_q.size()), 32'(exp_q.size()));
    first_cyc = (got_q.size() > 0) ? got_q[0].cyc : 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_data"}, 32'(g.data), 32'(e.data));
      check({tag, "_perr"}, 32'(g.perr), 32'(e.perr));
      check({tag, "_ferr"}, 32'(g.ferr), 32'(e.ferr));
    end
    exp_q.delete();
    got_q.delete();
    check({tag, "_busy_idle"}, 32'(rx_busy_o), 32'd0);
  endtask

  vec_t        vecs[7];
  rec_t        mexp;
  int unsigned sc, fc, lat;

  initial begin
    vecs[0] = '{4'd8, 16'd433, 2'd0, 2'd0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{4'd5, 16'd40,  2'd2, 2'd0, 8'h13, 1'b0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0};
    vecs[2] = '{4'd5, 16'd40,  2'd2, 2'd0, 8'h13, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 1'b0};
    vecs[3] = '{4'd7, 16'd40,  2'd1, 2'd2, 8'h55, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{4'd6, 16'd40,  2'd0, 2'd1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h3F, 1'b0, 1'b0};
    vecs[5] = '{4'd9, 16'd25,  2'd3, 2'd3, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[6] = '{4'd8, 16'd25,  2'd2, 2'd0, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1};

    repeat (4) @(posedge sys_clk_i);
    #1;
    check("reset_data", 32'(rx_data_o), 32'd0);
    check("reset_flag", 32'(rx_data_flag_o), 32'd0);
    check("reset_perr", 32'(rx_parity_err_o), 32'd0);
    check("reset_ferr", 32'(rx_frame_err_o), 32'd0);
    check("reset_busy", 32'(rx_busy_o), 32'd0);
    rst_n_i = 1'b1;
    repeat (4) @(posedge sys_clk_i);
    #1;
    check("post_reset_busy", 32'(rx_busy_o), 32'd0);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].db, vecs[i].mx, vecs[i].par, vecs[i].stp, vecs[i].data,
                 vecs[i].pflip, vecs[i].s1, vecs[i].s2, 1'b0, mexp, sc);
      exp_q.push_back('{vecs[i].e_data, vecs[i].e_perr, vecs[i].e_ferr, 0});
      drain($sformatf("vec%0d", i), int'(vecs[i].mx), fc);
      if (i == 0) begin
        // Strobe lands about 9.5 bit periods after the start edge, plus sync latency.
        lat = fc - sc;
        check("a5_latency_window", 32'(lat >= 4123 - 8 && lat <= 4123 + 8), 32'd1);
      end
    end

    // Short low glitch on an idle line must be rejected as a false start.
    uart_data_bit = 4'd8; uart_bps_baud_cnt_max = 16'd40;
    uart_parity_bit = 2'd0; uart_stop_bit = 2'd0;
    drive_level(1'b0, 10);
    drive_level(1'b1, 2 * 41);
    drain("glitch", 40, fc);
    send_frame(4'd8, 16'd40, 2'd0, 2'd0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, mexp, sc);
    exp_q.push_back('{8'h3C, 1'b0, 1'b0, 0});
    drain("after_glitch", 40, fc);

    send_frame(4'd8, 16'd40, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, mexp, sc);
    send_frame(4'd8, 16'd40, 2'd0, 2'd0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, mexp, sc);
    exp_q.push_back('{8'h00, 1'b0, 1'b0, 0});
    exp_q.push_back('{8'hFF, 1'b0, 1'b0, 0});
    drain("back_to_back", 40, fc);

    // Reset in the middle of data bit 3 of a 0x81 frame.
    drive_level(1'b0, 41);
    drive_level(1'b1, 41);
    drive_level(1'b0, 41);
    drive_level(1'b0, 41);
    drive_level(1'b0, 20);
    rst_n_i = 1'b0;
    rx_i    = 1'b1;
    #1;
    check("midreset_data", 32'(rx_data_o), 32'd0);
    check("midreset_flag", 32'(rx_data_flag_o), 32'd0);
    check("midreset_busy", 32'(rx_busy_o), 32'd0);
    repeat (3) @(posedge sys_clk_i);
    #1;
    rst_n_i = 1'b1;
    drive_level(1'b1, 2 * 41);
    send_frame(4'd8, 16'd40, 2'd0, 2'd0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, mexp, sc);
    exp_q.push_back('{8'h81, 1'b0, 1'b0, 0});
    drain("after_reset", 40, fc);

    for (int g = 0; g < 15; g++) begin
      int nf;
      nf = int'($urandom_range(1, 3));
      for (int k = 0; k < nf; k++) begin
        send_frame(4'($urandom_range(3, 10)), 16'($urandom_range(3, 30)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                   bit'($urandom_range(0, 1)), mexp, sc);
        exp_q.push_back(mexp);
      end
      drain("rand", 30, fc);
    end

    check("stray_err_flags", 32'(stray), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_logic.md
Name: uart_rx_logic

Overview:
UART receive engine, the partner to the UART transmit logic. It uses the same runtime configuration: data bits, baud divisor, parity mode and stop-bit mode.
- Oversamples the asynchronous rx line with the system clock, detects a start bit and samples each bit at mid-period.
- Delivers one byte per frame with a single-cycle valid strobe and parity/framing error flags.
- Sits between the pad-side rx pin and the UART wrapper or register interface.

Parameters:
SYNC_STAGES, 2, flip-flop stages on rx_i before edge detection (minimum 2).

Ports:
sys_clk_i  in  1  system clock; one clock for the whole block.
rst_n_i  in  1  asynchronous, active-low reset.
uart_data_bit  in  4  data bits per frame: 5/6/7/8; any other value is treated as 8.
uart_bps_baud_cnt_max  in  16  clock frequency / baud rate - 1; bit period = max+1 clocks; minimum legal value 3.
uart_parity_bit  in  2  0 none, 1 odd, 2 even, 3 none.
uart_stop_bit  in  2  0 one, 1 1.5, 2 two, 3 one stop bit.
rx_i  in  1  asynchronous serial input; idles high.
rx_data_o  out  8  received data, LSB-aligned; unused upper bits are 0.
rx_data_flag_o  out  1  one-cycle strobe: rx_data_o and the error flags are valid.
rx_parity_err_o  out  1  parity mismatch; valid only with the strobe.
rx_frame_err_o  out  1  a checked stop bit was sampled 0; valid only with the strobe.
rx_busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; synchronizer flops 1 (line idle).
- Input conditioning: rx_i passes through SYNC_STAGES flops, plus one more flop for falling-edge detection (rx_s). Start detection latency is SYNC_STAGES+1 clocks.
- Configuration capture: all four config inputs are latched on start detection. Config changes mid-frame have no effect until the next frame.
- Baud counter:
  - Cleared to 0 on start detection.
  - Counts 0..max, then wraps to 0.
  - Sample point is baud_cnt == max>>1 (floor).
  - Held at 0 in IDLE.
- FSM states:
  - IDLE: a falling edge on rx_s -> START. A line held low does not retrigger; only an edge starts a frame.
  - START: at the sample point, rx_s==1 is a false start -> IDLE with no strobe. rx_s==0 -> DATA with bit_cnt=0.
  - DATA: at each sample point, store rx_s into data bit bit_cnt (LSB first). After bit data_bit-1 -> PARITY if parity mode is 1 or 2, else -> STOP.
  - PARITY: at the sample point, compare rx_s with the expected value. Odd mode expects ~^data. Even mode expects ^data. Only the configured width is used. Mismatch sets the internal parity error. -> STOP.
  - STOP:
    - First stop bit is sampled at its sample point.
    - Mode 2 (two stop bits): also sample the second stop bit one full period later.
    - Modes 0/1/3: return after the first stop bit. The extra half bit of 1.5 mode is not checked.
    - Any stop sample of 0 sets the frame error.
    - After the last checked sample -> IDLE.
- Output timing: on the clock after the final stop sample, rx_data_flag_o=1 for exactly one cycle, with rx_data_o and both error flags registered. The error flags return to 0 with the strobe. rx_data_o holds its value until the next strobe.
- Error handling: data is delivered even when parity or frame error is set.
- Frame error / break: after a frame error the FSM is in IDLE. A new frame starts only on a fresh falling edge.
- Back-to-back frames: IDLE is reached at mid-stop-bit, so the next start edge is caught with no lost frames.
- Reset mid-frame: immediate return to IDLE, no strobe, and the partial data is discarded.
- Arithmetic: baud_cnt is 16 bit; bit_cnt is 4 bit; max>>1 is computed combinationally from the latched max.

Decomposition:
- Package uart_pkg holds:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - parity codes (NONE=0, ODD=1, EVEN=2);
  - stop codes (ONE=0, ONE_HALF=1, TWO=2);
  - the data-width decode function (5..8, default 8).
- One sub-module is natural: uart_rx_sync, the SYNC_STAGES synchronizer plus falling-edge detector, with output rx_s and fall_pulse.

Test Plan:
- 8N1, max=433, serial byte 0xA5 -> one strobe about 9.5 bit periods after the start edge; rx_data_o=0xA5; both error flags 0; rx_busy_o low after the strobe.
- 5 data bits, even parity, byte 0x13 with correct parity bit 1 -> rx_data_o=0x13, parity_err=0; same frame with parity bit 0 -> parity_err=1, data still 0x13.
- 7 data bits, odd parity, two stop bits, byte 0x55 with the second stop bit driven 0 -> frame_err=1, rx_data_o=0x55, exactly one strobe.
- Low glitch of max/4 clocks on an idle line -> no strobe; FSM back in IDLE; a following valid 0x3C frame is received correctly.
- Two back-to-back 8N1 frames 0x00 then 0xFF with zero idle gap -> two strobes with the correct values, no errors.
- rst_n_i asserted during DATA bit 3 of a frame -> outputs 0 immediately, no strobe; the next full frame 0x81 is received correctly.
